// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel top: receive, filter, send one frame.
// Drives buffer addresses and handshakes; carries no pixel data.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rcv_req,
    input  logic              rcv_ack,
    input  logic              snd_req,
    output logic              snd_ack,
    output logic              ibuf_we,
    output logic [ADDR_W-1:0] ibuf_waddr,
    output logic              flt_start,
    input  logic              flt_done,
    output logic              obuf_re,
    output logic [ADDR_W-1:0] obuf_raddr,
    output logic              busy,
    output logic              ovr_err,
    output logic [7:0]        frame_cnt
);
    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   NW   = (ADDR_W + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_FSTART, S_FWAIT, S_READY, S_PRE, S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [ADDR_W-1:0] w_pix_nxt;
    logic [7:0]        r_frame_cnt;
    logic              r_ovr_err;
    logic              w_frame_inc;
    logic              w_last;
    logic [ADDR_W:0]   w_k2;

    assign w_last = (r_pix_cnt == LAST);
    // One extra bit so k+2 cannot wrap when N fills the address space
    assign w_k2   = {1'b0, r_pix_cnt} + (ADDR_W + 1)'(2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_frame_cnt <= '0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pix_cnt <= w_pix_nxt;
            if (w_frame_inc)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            if (rcv_ack && r_state != S_RECV)
                r_ovr_err <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pix_nxt   = r_pix_cnt;
        w_frame_inc = 1'b0;
        rcv_req     = 1'b0;
        ibuf_we     = 1'b0;
        ibuf_waddr  = '0;
        flt_start   = 1'b0;
        obuf_re     = 1'b0;
        obuf_raddr  = '0;
        snd_ack     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: w_next = S_RECV;
            S_RECV: begin
                rcv_req    = 1'b1;
                busy       = (r_pix_cnt != '0);
                ibuf_we    = rcv_ack;
                ibuf_waddr = r_pix_cnt;
                if (rcv_ack) begin
                    if (w_last) begin
                        w_pix_nxt = '0;
                        w_next    = S_FSTART;
                    end else begin
                        w_pix_nxt = r_pix_cnt + 1'b1;
                    end
                end
            end
            S_FSTART: begin
                flt_start = 1'b1;
                w_next    = S_FWAIT;
            end
            S_FWAIT: if (flt_done) w_next = S_READY;
            S_READY: begin
                if (snd_req) begin
                    obuf_re = 1'b1;
                    w_next  = S_PRE;
                end
            end
            S_PRE: begin
                obuf_re    = 1'b1;
                obuf_raddr = ADDR_W'(1);
                w_next     = S_SEND;
            end
            S_SEND: begin
                snd_ack = 1'b1;
                if (w_k2 < NW) begin
                    obuf_re    = 1'b1;
                    obuf_raddr = w_k2[ADDR_W-1:0];
                end
                if (w_last) begin
                    w_pix_nxt   = '0;
                    w_frame_inc = 1'b1;
                    w_next      = S_RECV;
                end else begin
                    w_pix_nxt = r_pix_cnt + 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            rcv_req    = 1'b0;
            ibuf_we    = 1'b0;
            ibuf_waddr = '0;
            flt_start  = 1'b0;
            obuf_re    = 1'b0;
            obuf_raddr = '0;
            snd_ack    = 1'b0;
            busy       = 1'b0;
        end
    end

    assign frame_cnt = rst ? 8'd0 : r_frame_cnt;
    assign ovr_err   = rst ? 1'b0 : r_ovr_err;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x4 frame (N=16).
// Inputs change 1 time unit after each rising edge; checks 1 unit later.
module tb_sobel_frame_ctrl;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rcv_req, rcv_ack, snd_req, snd_ack;
    logic          ibuf_we, flt_start, flt_done, obuf_re;
    logic          busy, ovr_err;
    logic [AW-1:0] ibuf_waddr, obuf_raddr;
    logic [7:0]    frame_cnt;

    int total = 0;
    int bad   = 0;

    sobel_frame_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .rcv_req(rcv_req), .rcv_ack(rcv_ack),
        .snd_req(snd_req), .snd_ack(snd_ack),
        .ibuf_we(ibuf_we), .ibuf_waddr(ibuf_waddr),
        .flt_start(flt_start), .flt_done(flt_done),
        .obuf_re(obuf_re), .obuf_raddr(obuf_raddr),
        .busy(busy), .ovr_err(ovr_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the RECV cycle just before the first ack attempt
    task automatic recv(input bit gapped);
        int n = 0;
        int c = 0;
        while (n < N && c < 200) begin
            tick();
            rcv_ack = gapped ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            #1;
            chk("rcv_req", rcv_req, 1);
            chk("ibuf_we", ibuf_we, rcv_ack);
            if (n == 0) chk("busy_idle", busy, 0);
            if (rcv_ack) begin
                chk("waddr", ibuf_waddr, n);
                n++;
            end
            c++;
        end
        chk("recv_count", n, N);
        tick();
        rcv_ack = 1'b0;
        #1;
        chk("rcv_req_drop", rcv_req, 0);
        chk("flt_start", flt_start, 1);
        chk("busy_filt", busy, 1);
    endtask

    // Entered in the flt_start cycle; ends in the READY cycle
    task automatic filt(input int dly, input bit early, input bit ovr);
        snd_req = early;
        #1;
        chk("ack_fstart", snd_ack, 0);
        for (int j = 1; j < dly; j++) begin
            tick();
            rcv_ack = ovr && (j == 2);
            #1;
            chk("flt_start_once", flt_start, 0);
            chk("ack_wait", snd_ack, 0);
            chk("we_wait", ibuf_we, 0);
            if (ovr && j == 3) chk("ovr_set", ovr_err, 1);
        end
        tick();
        rcv_ack  = 1'b0;
        flt_done = 1'b1;
        #1;
        chk("ack_done", snd_ack, 0);
        tick();
        flt_done = 1'b0;
        snd_req  = 1'b1;
        #1;
        chk("ready_re", obuf_re, 1);
        chk("ready_raddr", obuf_raddr, 0);
        chk("ready_ack", snd_ack, 0);
    endtask

    task automatic send(input int exp_frames);
        tick();
        #1;
        chk("pre_re", obuf_re, 1);
        chk("pre_raddr", obuf_raddr, 1);
        chk("pre_ack", snd_ack, 0);
        for (int k = 0; k < N; k++) begin
            tick();
            if (k == 2) snd_req = 1'b0;
            #1;
            chk("snd_ack", snd_ack, 1);
            chk("send_re", obuf_re, (k + 2 < N));
            if (k + 2 < N) chk("send_raddr", obuf_raddr, k + 2);
        end
        tick();
        #1;
        chk("ack_fall", snd_ack, 0);
        chk("rcv_req_again", rcv_req, 1);
        chk("frame_cnt", frame_cnt, exp_frames);
    endtask

    initial begin
        rst = 1'b1;
        rcv_ack = 1'b0;
        snd_req = 1'b0;
        flt_done = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rcv_req", rcv_req, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_ovr", ovr_err, 0);
        rst = 1'b0;
        #1;
        chk("idle_busy", busy, 1);
        chk("idle_rcv_req", rcv_req, 0);

        recv(1'b0);
        filt(5, 1'b0, 1'b0);
        send(1);
        chk("ovr_clean", ovr_err, 0);

        recv(1'b1);
        filt(20, 1'b1, 1'b1);
        send(2);
        chk("ovr_sticky", ovr_err, 1);

        for (int i = 0; i < 7; i++) begin
            tick();
            rcv_ack = 1'b1;
            #1;
            chk("part_waddr", ibuf_waddr, i);
        end
        tick();
        rst = 1'b1;
        rcv_ack = 1'b0;
        #1;
        chk("mid_rst_req", rcv_req, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_idle_req", rcv_req, 0);
        chk("mid_idle_busy", busy, 1);
        chk("mid_frame", frame_cnt, 0);
        chk("mid_ovr", ovr_err, 0);

        recv(1'b0);
        filt(5, 1'b0, 1'b0);
        send(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
